grant_arbiter_fsm: RTL and testbench
====================================

GRANT_ARBITER_FSM -- requirements
Module: grant_arbiter_fsm

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 0, meaning max consecutive grant cycles while the other requester waits; 0 = unlimited.
REQ-002 The block SHALL have parameter HOLD_W, default 8, meaning hold-counter width; MAX_HOLD SHALL fit in HOLD_W bits.
REQ-003 The block SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port i_req_0  input  1  request from requester 0, level-held while service is wanted.
REQ-006 The block SHALL have port i_req_1  input  1  request from requester 1, level-held while service is wanted.
REQ-007 The block SHALL have port o_gnt_0  output  1  grant to requester 0, registered.
REQ-008 The block SHALL have port o_gnt_1  output  1  grant to requester 1, registered.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, GNT0, GNT1; o_gnt_0=1 only in GNT0, o_gnt_1=1 only in GNT1, both 0 in IDLE.
REQ-010 o_gnt_0 and o_gnt_1 SHALL never be 1 in the same cycle.
REQ-011 From IDLE, a request sampled on edge N SHALL assert the grant in the cycle after edge N (1-cycle latency).
REQ-012 From IDLE with only i_req_0=1 the FSM SHALL go to GNT0; with only i_req_1=1, to GNT1; with neither, stay in IDLE.
REQ-013 From IDLE with both requests =1, without RR the FSM SHALL go to GNT0 (requester 0 fixed priority).
REQ-014 In GNT0, while i_req_0=1 and no hold limit is hit, the FSM SHALL stay in GNT0 regardless of i_req_1.
REQ-015 In GNT0, when i_req_0=0: if i_req_1=1, the FSM SHALL go directly to GNT1 with no IDLE cycle; otherwise, to IDLE.
REQ-016 GNT1 SHALL mirror REQ-014/015 with the roles of 0 and 1 swapped.
REQ-017 The hold counter SHALL clear on every state change and increment each cycle the FSM stays in GNT0/GNT1, saturating at all-ones.
REQ-018 If MAX_HOLD>0, the FSM is in GNTx, the count has reached MAX_HOLD-1 and the other request =1, the FSM SHALL switch to the other GNT state on the next edge even if the current request is still 1.
REQ-019 If MAX_HOLD>0 and the other request =0, the current grant SHALL be held indefinitely.
REQ-020 Request glitches shorter than one clock period between edges SHALL have no effect; only values sampled at rising edges count.

Reset
REQ-021 While i_rst=1 at a rising edge, the FSM SHALL go to IDLE, o_gnt_0=0, o_gnt_1=0, the hold counter SHALL clear and the last-granted flag SHALL be set to requester 1.
REQ-022 Reset asserted mid-grant SHALL drop the grant on the next edge; after release, arbitration SHALL resume from IDLE per REQ-011.

Configuration
REQ-023 With macro GRANT_ARBITER_FSM_RR_EN defined, simultaneous requests in IDLE SHALL grant the requester not granted most recently (last-granted flag, updated on each entry to GNT0/GNT1).
REQ-024 Without GRANT_ARBITER_FSM_RR_EN, REQ-013 fixed priority SHALL apply and the last-granted flag SHALL not be implemented.

Structure
REQ-025 The state encoding (typedef: IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and the requester-index constants SHALL be in shared package grant_arbiter_pkg.
REQ-026 The saturating hold counter SHALL be a sub-module named grant_hold_cnt (inputs clk, rst, clr, en; output count).
REQ-027 The outputs SHALL be decoded from the state register with no combinational path from the inputs to the outputs.

Verification
REQ-028 Reset for 6 cycles, no requests -> both grants 0 throughout and 3 cycles after release.
REQ-029 i_req_0=1 at cycle 10, i_req_1=1 at 60, i_req_0=0 at 110, i_req_1=0 at 160 -> o_gnt_0 high cycles 11-110, o_gnt_1 high cycles 111-160, then both 0.
REQ-030 Both requests rise at the same edge from IDLE -> o_gnt_0=1 without RR; with RR_EN after reset, o_gnt_0=1, and on a second simultaneous request after IDLE, o_gnt_1=1.
REQ-031 MAX_HOLD=4, both requests held high -> grants alternate every 4 cycles, never overlapping.
REQ-032 i_rst=1 for 1 cycle while o_gnt_1=1 with i_req_1 held high -> o_gnt_1 falls at the reset edge and returns 1 cycle after reset release.
REQ-033 Every cycle in all tests -> assert !(o_gnt_0 && o_gnt_1).

Source files
------------

// File: rtl/grant_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grant_arbiter_pkg
// Description : Shared definitions for the two-requester grant arbiter:
//               the FSM state encoding and the requester-index constants.
// Revision    : 1.0 - initial release
// ============================================================================
package grant_arbiter_pkg;

    // Arbiter FSM states. Each grant output is a direct decode of one state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    // Requester indices. These are the values held by the last-granted flag.
    localparam logic c_REQ_0 = 1'b0;
    localparam logic c_REQ_1 = 1'b1;

endpackage : grant_arbiter_pkg
`default_nettype wire

// File: rtl/grant_hold_cnt.sv
`default_nettype none
// ============================================================================
// Module      : grant_hold_cnt
// Description : Saturating up-counter that measures how long the current
//               grant has been held. A clear takes priority over an
//               increment. Once the count reaches all-ones it stops there.
// Revision    : 1.0 - initial release
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset (clears count)
//               clr   - synchronous clear
//               en    - increment enable
//               count - current count value [HOLD_W-1:0]
// ============================================================================
module grant_hold_cnt
    import grant_arbiter_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [HOLD_W-1:0] count
);

    logic [HOLD_W-1:0] r_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else if (clr) begin
            r_count_q <= '0;
        end else if (en && (r_count_q != {HOLD_W{1'b1}})) begin
            r_count_q <= r_count_q + 1'b1;
        end
    end

    assign count = r_count_q;

endmodule : grant_hold_cnt
`default_nettype wire

// File: rtl/grant_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module      : grant_arbiter_fsm
// Description : Two-requester arbiter built around a three-state FSM
//               (IDLE / GNT0 / GNT1). Requests are level-held. The grant is
//               registered and has one cycle of latency. On a hand-off between
//               requesters the grant moves directly from one to the other
//               without passing through IDLE. An optional hold limit
//               (MAX_HOLD) forces a hand-off when the other requester is
//               waiting.
// Revision    : 1.0 - initial release
// Config      : GRANT_ARBITER_FSM_RR_EN - when defined, simultaneous requests
//               seen in IDLE go to the requester that was not granted most
//               recently. When undefined, requester 0 has fixed priority.
// Parameters  : MAX_HOLD - max consecutive grant cycles while the other
//                          requester waits (0 = unlimited)
//               HOLD_W   - hold-counter width (MAX_HOLD must fit)
// Ports       : i_clk   - clock, rising edge
//               i_rst   - synchronous active-high reset
//               i_req_0 - request from requester 0
//               i_req_1 - request from requester 1
//               o_gnt_0 - grant to requester 0 (state decode)
//               o_gnt_1 - grant to requester 1 (state decode)
// ============================================================================
module grant_arbiter_fsm
    import grant_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 0,
    parameter int HOLD_W   = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_0,
    input  logic i_req_1,
    output logic o_gnt_0,
    output logic o_gnt_1
);

    // The counter reads N-1 during the Nth cycle of a grant. The limit is
    // therefore reached when the count equals MAX_HOLD-1.
    localparam logic [HOLD_W-1:0] c_HOLD_LAST =
        (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_e            r_state_q;
    state_e            w_state_d;
    logic [HOLD_W-1:0] w_hold_cnt;
    logic              w_hold_hit;
    logic              w_cnt_clr;
    logic              w_cnt_en;

`ifdef GRANT_ARBITER_FSM_RR_EN
    logic r_last_q;     // requester granted most recently
`endif

    assign w_hold_hit = (MAX_HOLD > 0) && (w_hold_cnt >= c_HOLD_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE: begin
                if (i_req_0 && i_req_1) begin
`ifdef GRANT_ARBITER_FSM_RR_EN
                    w_state_d = (r_last_q == c_REQ_1) ? GNT0 : GNT1;
`else
                    w_state_d = GNT0;
`endif
                end else if (i_req_0) begin
                    w_state_d = GNT0;
                end else if (i_req_1) begin
                    w_state_d = GNT1;
                end
            end
            GNT0: begin
                if (!i_req_0) begin
                    w_state_d = i_req_1 ? GNT1 : IDLE;
                end else if (w_hold_hit && i_req_1) begin
                    w_state_d = GNT1;
                end
            end
            GNT1: begin
                if (!i_req_1) begin
                    w_state_d = i_req_0 ? GNT0 : IDLE;
                end else if (w_hold_hit && i_req_0) begin
                    w_state_d = GNT0;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register (and last-granted flag when round-robin is built in)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

`ifdef GRANT_ARBITER_FSM_RR_EN
    // Resetting to requester 1 means the first tie after reset goes to
    // requester 0. That matches the fixed-priority behaviour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_q <= c_REQ_1;
        end else if (w_state_d == GNT0) begin
            r_last_q <= c_REQ_0;
        end else if (w_state_d == GNT1) begin
            r_last_q <= c_REQ_1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Hold counter: cleared on any state change. It counts only while a
    // grant is being held.
    // ------------------------------------------------------------------
    assign w_cnt_clr = (w_state_d != r_state_q);
    assign w_cnt_en  = !w_cnt_clr && (r_state_q != IDLE);

    grant_hold_cnt #(
        .HOLD_W (HOLD_W)
    ) u_hold_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .count (w_hold_cnt)
    );

    // Outputs depend only on the state register.
    assign o_gnt_0 = (r_state_q == GNT0);
    assign o_gnt_1 = (r_state_q == GNT1);

endmodule : grant_arbiter_fsm
`default_nettype wire

// File: tb/tb_grant_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_grant_arbiter_fsm
// Description : Self-checking bench for grant_arbiter_fsm. Two instances
//               share the same stimulus: one with an unlimited hold, one with
//               MAX_HOLD=4. A behavioural owner/held-cycles model predicts
//               the grants of each instance.
// Revision    : 1.0 - initial release
// Config      : GRANT_ARBITER_FSM_RR_EN selects the round-robin tie rule in
//               the model as well as in the design.
// ============================================================================
module tb_grant_arbiter_fsm;

    logic clk = 1'b0;
    logic rst;
    logic req0;
    logic req1;
    logic gnt0_a, gnt1_a;
    logic gnt0_b, gnt1_b;

    always #5 clk = ~clk;

    grant_arbiter_fsm #(
        .MAX_HOLD (0),
        .HOLD_W   (8)
    ) u_dut_a (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req_0 (req0),
        .i_req_1 (req1),
        .o_gnt_0 (gnt0_a),
        .o_gnt_1 (gnt1_a)
    );

    grant_arbiter_fsm #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) u_dut_b (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req_0 (req0),
        .i_req_1 (req1),
        .o_gnt_0 (gnt0_b),
        .o_gnt_1 (gnt1_b)
    );

    // Model state per instance: owner (-1 none, 0, 1), cycles the current
    // owner has held the grant, and the last requester that was granted.
    int own  [2];
    int held [2];
    int lst  [2];
    int mh   [2] = '{0, 4};

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input bit r0, input bit r1, input bit rs);
        int  nxt;
        int  oth;
        bit  r [2];
        r[0] = r0;
        r[1] = r1;
        if (rs) begin
            own[k]  = -1;
            held[k] = 0;
            lst[k]  = 1;
        end else begin
            if (own[k] < 0) begin
                if (r[0] && r[1]) begin
`ifdef GRANT_ARBITER_FSM_RR_EN
                    nxt = 1 - lst[k];
`else
                    nxt = 0;
`endif
                end else if (r[0]) nxt = 0;
                else if (r[1])     nxt = 1;
                else               nxt = -1;
            end else begin
                oth = 1 - own[k];
                if (!r[own[k]])                            nxt = r[oth] ? oth : -1;
                else if (mh[k] > 0 && held[k] >= mh[k] && r[oth]) nxt = oth;
                else                                       nxt = own[k];
            end
            if (nxt != own[k]) held[k] = (nxt >= 0) ? 1 : 0;
            else if (nxt >= 0) held[k] = held[k] + 1;
            if (nxt >= 0) lst[k] = nxt;
            own[k] = nxt;
        end
    endtask

    // One clock cycle. Drive the inputs away from the edge, with an optional
    // short inverted pulse first. Let the edge sample them, advance the model,
    // then check both instances 1 time unit after the edge.
    task automatic cycle(input bit r0, input bit r1, input bit rs, input bit glitch);
        if (glitch) begin
            req0 = !r0;
            req1 = !r1;
            #2;
        end
        req0 = r0;
        req1 = r1;
        rst  = rs;
        @(posedge clk);
        cyc++;
        model_step(0, r0, r1, rs);
        model_step(1, r0, r1, rs);
        #1;
        chk("gnt0_a",  gnt0_a, own[0] == 0);
        chk("gnt1_a",  gnt1_a, own[0] == 1);
        chk("gnt0_b",  gnt0_b, own[1] == 0);
        chk("gnt1_b",  gnt1_b, own[1] == 1);
        chk("excl_a",  gnt0_a && gnt1_a, 1'b0);
        chk("excl_b",  gnt0_b && gnt1_b, 1'b0);
    endtask

    initial begin
        bit r0, r1, rs, gl;
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        own  = '{-1, -1};
        held = '{0, 0};
        lst  = '{1, 1};

        // Reset for 6 cycles with no requests, then 3 idle cycles.
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

        // Staggered requests: req0, then req1 joins, req0 leaves, req1 leaves.
        for (int i = 0; i < 50; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 50; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 50; i++) cycle(0, 1, 0, 0);
        for (int i = 0; i < 5;  i++) cycle(0, 0, 0, 0);

        // Simultaneous requests from IDLE after reset, then a second tie.
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);

        // Both held high: the MAX_HOLD=4 instance alternates.
        for (int i = 0; i < 30; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 2;  i++) cycle(0, 0, 0, 0);

        // Reset pulse while requester 1 holds the grant.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Randomised level-held requests, with glitches and occasional resets.
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) r0 = !r0;
            if ($urandom_range(3) == 0) r1 = !r1;
            rs = ($urandom_range(99) == 0);
            gl = ($urandom_range(7) == 0);
            cycle(r0, r1, rs, gl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_grant_arbiter_fsm
`default_nettype wire
